sensors_height_engine: RTL and testbench

- Parametrised, sequential successor to the combinational four-sensor height block.
- Accepts one frame of NUM_SENSORS distance readings through a valid/ready handshake and discards pairs with a failed sensor (zero reading).
- Computes the rounded mean of the surviving readings with a multi-cycle accumulator and restoring divider, then presents height plus diagnostics to the sqrt/display stage through a valid/ready output.

---
 rtl/sensors_height_engine.sv | 117 +++++++++++
 tb/tb_sensors_height_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sensors_height_engine.sv
// sensors_height_engine: rounded mean of valid sensor pairs via accumulator + restoring divider; ports clk rst, in_valid/in_ready/sensors in, out_valid/out_ready/height/valid_pairs/fault out; optional SENSORS_HEIGHT_FILTER_EN adds a 2-tap IIR on height
module sensors_height_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SENSORS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0]   sensors,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               height,
  output logic [$clog2(NUM_SENSORS/2+1)-1:0]  valid_pairs,
  output logic                                fault
);
  localparam int P     = NUM_SENSORS / 2;
  localparam int SUM_W = DATA_WIDTH + $clog2(NUM_SENSORS);
  localparam int VP_W  = $clog2(P + 1);
  localparam int CW    = $clog2(NUM_SENSORS + 1);
  localparam int DC_W  = $clog2(SUM_W + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DIVIDE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  logic [1:0]                        state;
  logic [NUM_SENSORS*DATA_WIDTH-1:0] rd;
  logic [VP_W-1:0]                   idx, vp;
  logic [SUM_W-1:0]                  sum, sum_n, q, q_n, rem, rem_n;
  logic [CW-1:0]                     cnt, cnt_n;
  logic [DC_W-1:0]                   dc;
  logic [DATA_WIDTH-1:0]             a, b, raw, res;
  logic [SUM_W:0]                    trial;
  logic                              pv, ge;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    a     = rd[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    b     = rd[(int'(idx)+P)*DATA_WIDTH +: DATA_WIDTH];
    pv    = a != '0 && b != '0;
    sum_n = pv ? sum + SUM_W'(a) + SUM_W'(b) : sum;
    cnt_n = pv ? cnt + CW'(2) : cnt;
    trial = {rem, q[SUM_W-1]};
    ge    = trial >= (SUM_W+1)'(cnt);
    rem_n = ge ? SUM_W'(trial - (SUM_W+1)'(cnt)) : trial[SUM_W-1:0];
    q_n   = {q[SUM_W-2:0], ge};
    raw   = q_n[DATA_WIDTH-1:0];
  end
`ifdef SENSORS_HEIGHT_FILTER_EN
  logic [DATA_WIDTH-1:0] filt;
  logic                  primed;
  logic [DATA_WIDTH:0]   fsum;
  always_comb begin
    fsum = {1'b0, filt} + {1'b0, raw} + (DATA_WIDTH+1)'(1);
    res  = primed ? fsum[DATA_WIDTH:1] : raw;
  end
  always_ff @(posedge clk)
    if (rst) begin
      filt   <= '0;
      primed <= 1'b0;
    end else if (state == DIVIDE && dc == DC_W'(SUM_W-1) && cnt != '0) begin
      filt   <= res;
      primed <= 1'b1;
    end
`else
  assign res = raw;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      rd          <= '0;
      idx         <= '0;
      vp          <= '0;
      sum         <= '0;
      cnt         <= '0;
      q           <= '0;
      rem         <= '0;
      dc          <= '0;
      height      <= '0;
      valid_pairs <= '0;
      fault       <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          rd    <= sensors;
          idx   <= '0;
          vp    <= '0;
          sum   <= '0;
          cnt   <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          sum <= sum_n;
          cnt <= cnt_n;
          vp  <= vp + VP_W'(pv);
          idx <= idx + VP_W'(1);
          if (idx == VP_W'(P-1)) begin
            q     <= sum_n + SUM_W'(cnt_n >> 1);
            rem   <= '0;
            dc    <= '0;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          q   <= q_n;
          rem <= rem_n;
          dc  <= dc + DC_W'(1);
          if (dc == DC_W'(SUM_W-1)) begin
            height      <= cnt == '0 ? '0 : res;
            fault       <= cnt == '0;
            valid_pairs <= vp;
            state       <= DONE;
          end
        end
        default: if (out_ready) state <= IDLE;
      endcase
endmodule

// File: tb/tb_sensors_height_engine.sv
// tb_sensors_height_engine: directed scoreboard bench for sensors_height_engine
module tb_sensors_height_engine;
  typedef struct {
    logic [7:0] h;
    logic [1:0] vp;
    logic       f;
  } exp_t;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] sensors = '0;
  logic        in_ready, out_valid, fault;
  logic [7:0]  height;
  logic [1:0]  valid_pairs;
  logic        rst6 = 1, iv6 = 0, ir6, ov6, f6;
  logic [71:0] s6 = '0;
  logic [11:0] h6;
  logic [1:0]  vp6;
  int          errors = 0, checks = 0;
  exp_t        sb[$];
  exp_t        last;
  logic [7:0]  mf = 0;
  bit          mp = 0;
  always #5 clk = ~clk;
  sensors_height_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sensors(sensors),
    .out_valid(out_valid), .out_ready(out_ready), .height(height),
    .valid_pairs(valid_pairs), .fault(fault));
  sensors_height_engine #(.DATA_WIDTH(12), .NUM_SENSORS(6)) dut6 (
    .clk(clk), .rst(rst6), .in_valid(iv6), .in_ready(ir6), .sensors(s6),
    .out_valid(ov6), .out_ready(1'b1), .height(h6), .valid_pairs(vp6), .fault(f6));
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  function automatic logic [7:0] model_h(input logic [7:0] raw, input logic f);
    logic [8:0] t;
    if (f) return 8'd0;
`ifdef SENSORS_HEIGHT_FILTER_EN
    t  = {1'b0, mf} + {1'b0, raw} + 9'd1;
    mf = mp ? t[8:1] : raw;
    mp = 1;
    return mf;
`else
    return raw;
`endif
  endfunction
  function automatic void ref_model(input logic [31:0] s, output logic [7:0] raw,
                                    output logic [1:0] vp, output logic f);
    int sum = 0, c = 0;
    logic [7:0] a, b;
    for (int k = 0; k < 2; k++) begin
      a = s[k*8 +: 8];
      b = s[(k+2)*8 +: 8];
      if (a != 0 && b != 0) begin
        sum += a + b;
        c += 2;
      end
    end
    vp  = 2'(c / 2);
    f   = c == 0;
    raw = f ? 8'd0 : 8'((sum + c / 2) / c);
  endfunction
  task automatic send(input logic [31:0] s, input logic [7:0] raw, input logic [1:0] vp,
                      input logic f);
    exp_t e;
    e.h = model_h(raw, f);
    e.vp = vp;
    e.f = f;
    sb.push_back(e);
    in_valid = 1;
    sensors = s;
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("busy_in_ready", in_ready, 0);
  endtask
  task automatic collect();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 12);
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      last = sb.pop_front();
      chk("height", height, last.h);
      chk("valid_pairs", valid_pairs, last.vp);
      chk("fault", fault, last.f);
    end
  endtask
  task automatic release_out();
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("hold_height", height, last.h);
  endtask
  initial begin
    logic [7:0]  r;
    logic [1:0]  v;
    logic        f;
    logic [31:0] s;
    int          n;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    rst6 = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_height", height, 0);
    chk("rst_valid_pairs", valid_pairs, 0);
    chk("rst_fault", fault, 0);
    send({8'd41, 8'd30, 8'd20, 8'd10}, 8'd25, 2'd2, 1'b0);
    collect();
    release_out();
    send({8'd41, 8'd30, 8'd20, 8'd0}, 8'd31, 2'd1, 1'b0);
    collect();
    release_out();
    send({8'd7, 8'd5, 8'd0, 8'd0}, 8'd0, 2'd0, 1'b1);
    collect();
    release_out();
    send({8'd255, 8'd255, 8'd255, 8'd255}, 8'd255, 2'd2, 1'b0);
    collect();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      sensors = {8'd1, 8'd2, 8'd3, 8'd4};
      @(posedge clk);
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_height", height, last.h);
    end
    in_valid = 0;
    release_out();
    @(posedge clk);
    #1;
    chk("no_capture", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      s = {8'(i % 3 == 0 ? 0 : $urandom_range(1, 255)), 8'($urandom_range(1, 255)),
           8'($urandom_range(0, 255)), 8'($urandom_range(1, 255))};
      ref_model(s, r, v, f);
      send(s, r, v, f);
      collect();
      release_out();
    end
    send({8'd41, 8'd30, 8'd20, 8'd10}, 8'd25, 2'd2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    sb.delete();
    mp = 0;
    mf = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_height", height, 0);
    chk("abort_in_ready", in_ready, 1);
    send({8'd41, 8'd30, 8'd20, 8'd10}, 8'd25, 2'd2, 1'b0);
    collect();
    release_out();
    send({8'd41, 8'd30, 8'd20, 8'd0}, 8'd31, 2'd1, 1'b0);
    collect();
    release_out();
    iv6 = 1;
    s6 = {6{12'd4095}};
    @(posedge clk);
    #1;
    iv6 = 0;
    n = 0;
    while (!ov6 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w12_latency", n, 18);
    chk("w12_height", h6, 4095);
    chk("w12_valid_pairs", vp6, 3);
    chk("w12_fault", f6, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
